// File: rtl/counter_updown_mod.sv
// Up/down counter with programmable inclusive limit, step magnitude and
// wrap-or-saturate overflow behaviour; one-cycle ovf/unf/load_err pulses.
module counter_updown_mod #(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4,
    parameter int SAT_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              load,
    input  logic              up_down,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  max_val,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_zero,
    output logic              ovf,
    output logic              unf,
    output logic              load_err
);

    localparam int EW = WIDTH + 1;

    logic [EW-1:0]    count_x;
    logic [EW-1:0]    max_x;
    logic [EW-1:0]    mod_x;
    logic [EW-1:0]    step_x;
    logic [EW-1:0]    s_x;
    logic [EW-1:0]    sum_x;
    logic [EW-1:0]    wrap_up_x;
    logic [EW-1:0]    wrap_dn_x;
    logic [EW-1:0]    diff_x;
    logic             above_max;
    logic             step_zero;
    logic             up_over;
    logic             dn_under;

    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic             load_err_nxt;

    // All step arithmetic is one bit wider than the counter so that
    // count + s and count + (max_val + 1) never lose a carry.
    always_comb begin
        count_x   = {1'b0, count};
        max_x     = {1'b0, max_val};
        mod_x     = max_x + EW'(1);
        step_x    = {{(EW-STEP_W){1'b0}}, step};
        s_x       = (step_x < max_x) ? step_x : max_x;
        sum_x     = count_x + s_x;
        diff_x    = count_x - s_x;
        wrap_up_x = sum_x - mod_x;
        wrap_dn_x = count_x + mod_x - s_x;
        above_max = count_x > max_x;
        step_zero = (s_x == '0);
        up_over   = sum_x > max_x;
        dn_under  = count_x < s_x;
    end

    always_comb begin
        count_nxt    = count;
        ovf_nxt      = 1'b0;
        unf_nxt      = 1'b0;
        load_err_nxt = 1'b0;

        if (clear) begin
            count_nxt = '0;
        end else if (load) begin
            if (data_in > max_val) begin
                count_nxt    = max_val;
                load_err_nxt = 1'b1;
            end else begin
                count_nxt = data_in;
            end
        end else if (enable) begin
            // A limit lowered below the current count pulls the count back in
            // without reporting an overflow.
            if (above_max) begin
                count_nxt = max_val;
            end else if (step_zero) begin
                count_nxt = count;
            end else if (up_down) begin
                if (up_over) begin
                    ovf_nxt   = 1'b1;
                    count_nxt = (SAT_MODE != 0) ? max_val : wrap_up_x[WIDTH-1:0];
                end else begin
                    count_nxt = sum_x[WIDTH-1:0];
                end
            end else begin
                if (dn_under) begin
                    unf_nxt   = 1'b1;
                    count_nxt = (SAT_MODE != 0) ? '0 : wrap_dn_x[WIDTH-1:0];
                end else begin
                    count_nxt = diff_x[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_nxt;
            ovf      <= ovf_nxt;
            unf      <= unf_nxt;
            load_err <= load_err_nxt;
        end
    end

    assign at_max  = (count == max_val);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench: a wrap-mode and a saturate-mode counter share stimulus;
// a behavioural model queues expected results, a monitor pops and compares.
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b0, enable = 1'b0, clear = 1'b0, load = 1'b0, up_down = 1'b0;
    logic [3:0] data_in = '0, step = '0, max_val = '0;

    logic [3:0] count_w, count_s;
    logic       at_max_w, at_zero_w, ovf_w, unf_w, lerr_w;
    logic       at_max_s, at_zero_s, ovf_s, unf_s, lerr_s;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int cnt;
        bit ovf, unf, lerr, amax, azero;
    } exp_t;

    exp_t q_w[$];
    exp_t q_s[$];
    exp_t mon_w, mon_s;
    int   m_w = 0, m_s = 0;

    always #5 clk = ~clk;

    counter_updown_mod #(.WIDTH(4), .STEP_W(4), .SAT_MODE(0)) dut_wrap (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load),
        .up_down(up_down), .data_in(data_in), .step(step), .max_val(max_val),
        .count(count_w), .at_max(at_max_w), .at_zero(at_zero_w),
        .ovf(ovf_w), .unf(unf_w), .load_err(lerr_w));

    counter_updown_mod #(.WIDTH(4), .STEP_W(4), .SAT_MODE(1)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load),
        .up_down(up_down), .data_in(data_in), .step(step), .max_val(max_val),
        .count(count_s), .at_max(at_max_s), .at_zero(at_zero_s),
        .ovf(ovf_s), .unf(unf_s), .load_err(lerr_s));

    // Reference behaviour in plain integer arithmetic.
    function automatic exp_t model(input bit sat, input int c, input bit r, cl, ld, en, up,
                                   input int d, st, mx);
        exp_t e;
        int   s;
        e = '{cnt: c, ovf: 0, unf: 0, lerr: 0, amax: 0, azero: 0};
        s = (st < mx) ? st : mx;
        if (r || cl) begin
            e.cnt = 0;
        end else if (ld) begin
            e.lerr = (d > mx);
            e.cnt  = (d > mx) ? mx : d;
        end else if (en) begin
            if (c > mx) e.cnt = mx;
            else if (s == 0) e.cnt = c;
            else if (up) begin
                if (c + s > mx) begin
                    e.ovf = 1;
                    e.cnt = sat ? mx : (c + s) % (mx + 1);
                end else e.cnt = c + s;
            end else begin
                if (c < s) begin
                    e.unf = 1;
                    e.cnt = sat ? 0 : (c - s + mx + 1) % (mx + 1);
                end else e.cnt = c - s;
            end
        end
        e.amax  = (e.cnt == mx);
        e.azero = (e.cnt == 0);
        return e;
    endfunction

    task automatic cycle(input bit r, cl, ld, en, up, input int d, st, mx);
        exp_t e;
        @(negedge clk);
        rst = r; clear = cl; load = ld; enable = en; up_down = up;
        data_in = 4'(d); step = 4'(st); max_val = 4'(mx);
        e = model(1'b0, m_w, r, cl, ld, en, up, d, st, mx);
        m_w = e.cnt;
        q_w.push_back(e);
        e = model(1'b1, m_s, r, cl, ld, en, up, d, st, mx);
        m_s = e.cnt;
        q_s.push_back(e);
        @(posedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q_w.size() > 0) begin
            mon_w = q_w.pop_front();
            tests++;
            if (count_w !== 4'(mon_w.cnt) || ovf_w !== mon_w.ovf || unf_w !== mon_w.unf ||
                lerr_w !== mon_w.lerr || at_max_w !== mon_w.amax || at_zero_w !== mon_w.azero) begin
                fails++;
                $display("FAIL wrap_sb @%0t: got cnt=%0d ovf=%b unf=%b lerr=%b amax=%b azero=%b expected cnt=%0d ovf=%b unf=%b lerr=%b amax=%b azero=%b",
                         $time, count_w, ovf_w, unf_w, lerr_w, at_max_w, at_zero_w,
                         mon_w.cnt, mon_w.ovf, mon_w.unf, mon_w.lerr, mon_w.amax, mon_w.azero);
            end
        end
        if (q_s.size() > 0) begin
            mon_s = q_s.pop_front();
            tests++;
            if (count_s !== 4'(mon_s.cnt) || ovf_s !== mon_s.ovf || unf_s !== mon_s.unf ||
                lerr_s !== mon_s.lerr || at_max_s !== mon_s.amax || at_zero_s !== mon_s.azero) begin
                fails++;
                $display("FAIL sat_sb @%0t: got cnt=%0d ovf=%b unf=%b lerr=%b amax=%b azero=%b expected cnt=%0d ovf=%b unf=%b lerr=%b amax=%b azero=%b",
                         $time, count_s, ovf_s, unf_s, lerr_s, at_max_s, at_zero_s,
                         mon_s.cnt, mon_s.ovf, mon_s.unf, mon_s.lerr, mon_s.amax, mon_s.azero);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int mx;
        // reset state
        cycle(1, 0, 0, 0, 0, 0, 0, 9);
        #1; chk("reset_cnt_w", int'(count_w), 0); chk("reset_cnt_s", int'(count_s), 0);

        // wrap past max_val, then a normal step
        cycle(0, 0, 1, 0, 0, 8, 0, 9);
        cycle(0, 0, 0, 1, 1, 0, 3, 9);
        #1; chk("wrap_up_cnt", int'(count_w), 1); chk("wrap_up_ovf", int'(ovf_w), 1);
        chk("sat_up_cnt", int'(count_s), 9); chk("sat_up_ovf", int'(ovf_s), 1);
        cycle(0, 0, 0, 1, 1, 0, 3, 9);
        #1; chk("wrap_next_cnt", int'(count_w), 4); chk("wrap_next_ovf", int'(ovf_w), 0);
        chk("sat_again_ovf", int'(ovf_s), 1);

        // saturate at zero, repeated
        cycle(0, 0, 1, 0, 0, 2, 0, 9);
        cycle(0, 0, 0, 1, 0, 0, 4, 9);
        #1; chk("sat_dn_cnt", int'(count_s), 0); chk("sat_dn_unf", int'(unf_s), 1);
        chk("wrap_dn_cnt", int'(count_w), 8); chk("wrap_dn_unf", int'(unf_w), 1);
        cycle(0, 0, 0, 1, 0, 0, 4, 9);
        #1; chk("sat_dn2_cnt", int'(count_s), 0); chk("sat_dn2_unf", int'(unf_s), 1);
        chk("wrap_dn2_unf", int'(unf_w), 0);

        // oversize load clamps; clear beats load
        cycle(0, 0, 1, 0, 0, 12, 0, 9);
        #1; chk("load_clamp_cnt", int'(count_w), 9); chk("load_err", int'(lerr_w), 1);
        cycle(0, 1, 1, 0, 0, 12, 0, 9);
        #1; chk("clear_cnt", int'(count_w), 0); chk("clear_lerr", int'(lerr_w), 0);

        // runtime max_val drop below count
        cycle(0, 0, 1, 0, 0, 7, 0, 9);
        cycle(0, 0, 0, 1, 1, 0, 1, 5);
        #1; chk("lower_max_cnt", int'(count_w), 5); chk("lower_max_ovf", int'(ovf_w), 0);
        chk("lower_max_atmax", int'(at_max_w), 1);

        // reset beats load, then plain load
        cycle(1, 0, 1, 0, 0, 3, 0, 9);
        #1; chk("rst_load_cnt", int'(count_w), 0); chk("rst_load_lerr", int'(lerr_w), 0);
        cycle(0, 0, 1, 0, 0, 3, 0, 9);
        #1; chk("post_rst_load", int'(count_w), 3);

        // max_val == 0
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 1, 1'($urandom_range(1)), 0, $urandom_range(15), 0);
            #1; chk("max0_flags", int'({at_max_w, at_zero_w, at_max_s, at_zero_s}), 15);
        end

        // randomized traffic
        mx = 9;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(9) == 0) mx = $urandom_range(15);
            cycle(($urandom_range(49) == 0), ($urandom_range(19) == 0), ($urandom_range(9) == 0),
                  ($urandom_range(9) < 7), 1'($urandom_range(1)),
                  $urandom_range(15), $urandom_range(15), mx);
        end

        cycle(0, 0, 0, 0, 0, 0, 0, mx);
        #2;
        chk("sb_drained", q_w.size() + q_s.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/counter_updown_mod.md
COUNTER_UPDOWN_MOD -- requirements
Module: counter_updown_mod

Interface
REQ-001 Parameter WIDTH, default 8: counter, data_in and max_val width in bits; legal range 2..32.
REQ-002 Parameter STEP_W, default 4: step input width; SHALL satisfy STEP_W <= WIDTH.
REQ-003 Parameter SAT_MODE, default 0: 0 = wrap modulo (max_val+1); 1 = saturate at 0 and max_val.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  count-step qualifier.
REQ-007 clear  input  1  synchronous clear of count, independent of enable.
REQ-008 load  input  1  synchronous load of data_in, independent of enable.
REQ-009 up_down  input  1  1 = count up, 0 = count down.
REQ-010 data_in  input  WIDTH  load value.
REQ-011 step  input  STEP_W  increment/decrement magnitude per enabled cycle.
REQ-012 max_val  input  WIDTH  inclusive upper count limit, sampled every cycle.
REQ-013 count  output  WIDTH  registered counter value.
REQ-014 at_max  output  1  combinational: count == max_val.
REQ-015 at_zero  output  1  combinational: count == 0.
REQ-016 ovf  output  1  registered one-cycle pulse: up step crossed max_val.
REQ-017 unf  output  1  registered one-cycle pulse: down step crossed 0.
REQ-018 load_err  output  1  registered one-cycle pulse: load value exceeded max_val.

Function
REQ-019 Per-edge priority: rst > clear > load > enabled step > hold.
REQ-020 Count, ovf, unf, load_err SHALL all update on the same edge; each new value is visible one cycle after the qualifying inputs are sampled.
REQ-021 ovf, unf and load_err SHALL be 0 on every edge that does not itself raise them; no pulse SHALL last more than one cycle per event.
REQ-022 clear: count <= 0; ovf, unf and load_err <= 0.
REQ-023 load: count <= min(data_in, max_val); load_err <= 1 iff data_in > max_val.
REQ-024 Effective step s = min(step, max_val); s == 0 holds count with no pulse.
REQ-025 Enabled step with count > max_val (max_val lowered at runtime): count <= max_val, no pulse, regardless of direction or mode.
REQ-026 Up, count + s <= max_val: count <= count + s. Intermediate sums SHALL use WIDTH+1 bits so no carry is lost.
REQ-027 Up, count + s > max_val: ovf <= 1. Wrap mode: count <= count + s - (max_val+1). Saturate mode: count <= max_val.
REQ-028 Down, count >= s: count <= count - s.
REQ-029 Down, count < s: unf <= 1. Wrap mode: count <= count + (max_val+1) - s. Saturate mode: count <= 0.
REQ-030 Saturate mode: a step attempted while already at the limit in the same direction SHALL still pulse ovf or unf, and count SHALL stay unchanged.
REQ-031 max_val == 0: count stays 0 under any step; at_max = at_zero = 1; no ovf or unf.
REQ-032 enable = 0 with no clear and no load: count holds and all pulses are 0.

Reset
REQ-033 rst = 1 at an edge: count <= 0, ovf <= 0, unf <= 0, load_err <= 0, overriding all other inputs including a simultaneous clear or load.
REQ-034 Deasserting rst mid-sequence SHALL resume from count 0 on the next edge with no stale pulse.

Verification
REQ-035 WIDTH=4, wrap, max_val=9, step=3, up from count 8 -> count 1, ovf=1 for one cycle; next step -> count 4, ovf=0.
REQ-036 WIDTH=4, saturate, max_val=9, down, step=4, count 2 -> count 0, unf=1; repeat step -> count 0, unf=1 again.
REQ-037 Load data_in=12 with max_val=9 -> count 9, load_err=1; same cycle with clear=1 -> count 0, load_err=0.
REQ-038 count=7, max_val changed to 5, enable=1, up, step=1 -> count 5, no ovf; at_max=1.
REQ-039 rst=1 together with load=1, data_in=3 -> count 0, all pulses 0; enable=0, load=1, data_in=3 -> count 3.
REQ-040 max_val=0 with random up_down and step, enable=1 for 20 cycles -> count 0 throughout, at_max=at_zero=1, no ovf or unf.
